// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with generic exponent/fraction widths.
// Flow: IDLE -> CAPT -> (ALIGN) -> ADD -> (NORM) -> PACK -> IDLE.
// Rounding is truncation; subnormal inputs are flushed to zero.
module fp_addsub_seq #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] A,
   input  logic [EXP_W+MAN_W:0] B,
   output logic                 busy,
   output logic                 Done,
   output logic [EXP_W+MAN_W:0] Result,
   output logic                 ovf_flag,
   output logic                 unf_flag
);

   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned MW = MAN_W + 1;   // mantissa with hidden bit
   localparam int unsigned SW = MAN_W + 2;   // sum with carry bit

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CAPT  = 3'd1;
   localparam logic [2:0] S_ALIGN = 3'd2;
   localparam logic [2:0] S_ADD   = 3'd3;
   localparam logic [2:0] S_NORM  = 3'd4;
   localparam logic [2:0] S_PACK  = 3'd5;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // state and datapath registers
   logic [2:0]       r_state;
   logic [W-1:0]     r_a, r_b;
   logic             r_sx, r_sub, r_skip;
   logic [EXP_W-1:0] r_ex, r_ey, r_exp;
   logic [MW-1:0]    r_mx, r_my;
   logic [SW-1:0]    r_sum;
   logic [W-1:0]     r_res;
   logic             r_povf, r_punf;

   // next-state values
   logic [2:0]       w_state_nxt;
   logic [W-1:0]     w_a_nxt, w_b_nxt;
   logic             w_sx_nxt, w_sub_nxt, w_skip_nxt;
   logic [EXP_W-1:0] w_ex_nxt, w_ey_nxt, w_exp_nxt;
   logic [MW-1:0]    w_mx_nxt, w_my_nxt;
   logic [SW-1:0]    w_sum_nxt;
   logic [W-1:0]     w_res_nxt;
   logic             w_povf_nxt, w_punf_nxt;
   logic             w_busy_nxt, w_done_nxt, w_ovf_nxt, w_unf_nxt;
   logic [W-1:0]     w_result_nxt;

   // unpack/order helpers and arithmetic
   logic             w_a_ge;
   logic [W-1:0]     w_x, w_y;
   logic [EXP_W-1:0] w_ex, w_ey, w_diff;
   logic             w_bypass;
   logic [SW-1:0]    w_sum, w_shl;
   logic [EXP_W-1:0] w_ey_inc, w_exp_inc, w_exp_dec;

   // magnitude ordering: X is the larger operand, A wins a tie
   assign w_a_ge   = r_a[W-2:0] >= r_b[W-2:0];
   assign w_x      = w_a_ge ? r_a : r_b;
   assign w_y      = w_a_ge ? r_b : r_a;
   assign w_ex     = w_x[W-2:MAN_W];
   assign w_ey     = w_y[W-2:MAN_W];
   assign w_diff   = w_ex - w_ey;
   assign w_bypass = 32'(w_diff) > 32'(MAN_W + 1);

   // one-cycle mantissa sum; ordering keeps the difference non-negative
   assign w_sum     = r_sub ? (SW'(r_mx) - SW'(r_my)) : (SW'(r_mx) + SW'(r_my));
   assign w_shl     = r_sum << 1;
   assign w_ey_inc  = r_ey + EXP_W'(1);
   assign w_exp_inc = r_exp + EXP_W'(1);
   assign w_exp_dec = r_exp - EXP_W'(1);

   // next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_sx_nxt     = r_sx;
      w_sub_nxt    = r_sub;
      w_skip_nxt   = r_skip;
      w_ex_nxt     = r_ex;
      w_ey_nxt     = r_ey;
      w_exp_nxt    = r_exp;
      w_mx_nxt     = r_mx;
      w_my_nxt     = r_my;
      w_sum_nxt    = r_sum;
      w_res_nxt    = r_res;
      w_povf_nxt   = r_povf;
      w_punf_nxt   = r_punf;
      w_busy_nxt   = busy;
      w_done_nxt   = 1'b0;
      w_ovf_nxt    = ovf_flag;
      w_unf_nxt    = unf_flag;
      w_result_nxt = Result;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_nxt     = A;
               w_b_nxt     = {B[W-1] ^ op_sub, B[W-2:0]};
               w_busy_nxt  = 1'b1;
               w_ovf_nxt   = 1'b0;
               w_unf_nxt   = 1'b0;
               w_povf_nxt  = 1'b0;
               w_punf_nxt  = 1'b0;
               w_state_nxt = S_CAPT;
            end
         end

         S_CAPT: begin
            w_sx_nxt   = w_x[W-1];
            w_sub_nxt  = w_x[W-1] ^ w_y[W-1];
            w_ex_nxt   = w_ex;
            w_ey_nxt   = w_ey;
            w_mx_nxt   = (w_ex == '0) ? '0 : {1'b1, w_x[MAN_W-1:0]};
            w_my_nxt   = (w_ey == '0) ? '0 : {1'b1, w_y[MAN_W-1:0]};
            w_skip_nxt = 1'b1;
            // specials and bypass still pass through ADD so every op takes at least 3 cycles
            if (w_ex == EXP_ONES) begin
               if ((w_x[MAN_W-1:0] != '0) || ((w_ey == EXP_ONES) && (w_x[W-1] != w_y[W-1])))
                  w_res_nxt = QNAN;
               else
                  w_res_nxt = {w_x[W-1], EXP_ONES, {MAN_W{1'b0}}};
               w_state_nxt = S_ADD;
            end else if (w_bypass) begin
               w_res_nxt   = w_x;
               w_state_nxt = S_ADD;
            end else begin
               w_skip_nxt  = 1'b0;
               w_state_nxt = (w_ex == w_ey) ? S_ADD : S_ALIGN;
            end
         end

         S_ALIGN: begin
            w_my_nxt = r_my >> 1;
            w_ey_nxt = w_ey_inc;
            if (w_ey_inc == r_ex)
               w_state_nxt = S_ADD;
         end

         S_ADD: begin
            if (r_skip) begin
               w_state_nxt = S_PACK;
            end else if (w_sum == '0) begin
               w_res_nxt   = '0;
               w_state_nxt = S_PACK;
            end else if (w_sum[SW-1] || !w_sum[MAN_W]) begin
               w_sum_nxt   = w_sum;
               w_exp_nxt   = r_ex;
               w_state_nxt = S_NORM;
            end else begin
               w_res_nxt   = {r_sx, r_ex, w_sum[MAN_W-1:0]};
               w_state_nxt = S_PACK;
            end
         end

         S_NORM: begin
            if (r_sum[SW-1]) begin
               if (w_exp_inc == EXP_ONES) begin
                  w_res_nxt  = {r_sx, EXP_ONES, {MAN_W{1'b0}}};
                  w_povf_nxt = 1'b1;
               end else begin
                  w_res_nxt  = {r_sx, w_exp_inc, r_sum[MAN_W:1]};
               end
               w_state_nxt = S_PACK;
            end else if (r_exp <= EXP_W'(1)) begin
               w_res_nxt   = '0;
               w_punf_nxt  = 1'b1;
               w_state_nxt = S_PACK;
            end else begin
               w_sum_nxt = w_shl;
               w_exp_nxt = w_exp_dec;
               if (w_shl[MAN_W]) begin
                  w_res_nxt   = {r_sx, w_exp_dec, w_shl[MAN_W-1:0]};
                  w_state_nxt = S_PACK;
               end
            end
         end

         S_PACK: begin
            w_result_nxt = r_res;
            w_ovf_nxt    = r_povf;
            w_unf_nxt    = r_punf;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // register all state; reset aborts any operation in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sx     <= 1'b0;
         r_sub    <= 1'b0;
         r_skip   <= 1'b0;
         r_ex     <= '0;
         r_ey     <= '0;
         r_exp    <= '0;
         r_mx     <= '0;
         r_my     <= '0;
         r_sum    <= '0;
         r_res    <= '0;
         r_povf   <= 1'b0;
         r_punf   <= 1'b0;
         busy     <= 1'b0;
         Done     <= 1'b0;
         Result   <= '0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_sx     <= w_sx_nxt;
         r_sub    <= w_sub_nxt;
         r_skip   <= w_skip_nxt;
         r_ex     <= w_ex_nxt;
         r_ey     <= w_ey_nxt;
         r_exp    <= w_exp_nxt;
         r_mx     <= w_mx_nxt;
         r_my     <= w_my_nxt;
         r_sum    <= w_sum_nxt;
         r_res    <= w_res_nxt;
         r_povf   <= w_povf_nxt;
         r_punf   <= w_punf_nxt;
         busy     <= w_busy_nxt;
         Done     <= w_done_nxt;
         Result   <= w_result_nxt;
         ovf_flag <= w_ovf_nxt;
         unf_flag <= w_unf_nxt;
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: single precision plus a half-precision instance.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, op_sub;
   logic [31:0] A, B, Result;
   logic        busy, Done, ovf_flag, unf_flag;

   logic        start2, op_sub2;
   logic [15:0] A2, B2, Result2;
   logic        busy2, done2, ovf2, unf2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub), .A(A), .B(B),
      .busy(busy), .Done(Done), .Result(Result), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
   );

   fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_dut_h (
      .clk(clk), .reset_n(reset_n), .start(start2), .op_sub(op_sub2), .A(A2), .B(B2),
      .busy(busy2), .Done(done2), .Result(Result2), .ovf_flag(ovf2), .unf_flag(unf2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one operation; poke>0 raises start with other operands while busy
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int poke,
                         output logic [31:0] res, output logic ovf, output logic unf,
                         output logic bsy, output int lat);
      @(negedge clk);
      A = a; B = b; op_sub = sub; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 80; k++) begin
         if (k == poke) begin
            start = 1'b1; A = 32'h4040_0000; B = 32'h4040_0000; op_sub = 1'b0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (Done === 1'b1) begin
            lat = k;
            break;
         end
      end
      res = Result; ovf = ovf_flag; unf = unf_flag; bsy = busy;
   endtask

   task automatic op_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input int poke, input logic [31:0] e_res,
                           input int e_lat, input logic e_ovf, input logic e_unf);
      logic [31:0] res;
      logic        ovf, unf, bsy;
      int          lat;
      run_op(a, b, sub, poke, res, ovf, unf, bsy, lat);
      check({name, ".res"}, 64'(res), 64'(e_res));
      check({name, ".lat"}, 64'(lat), 64'(e_lat));
      check({name, ".ovf"}, 64'(ovf), 64'(e_ovf));
      check({name, ".unf"}, 64'(unf), 64'(e_unf));
      check({name, ".busy"}, 64'(bsy), 64'd0);
   endtask

   task automatic run_half(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic [15:0] e_res, input int e_lat);
      int lat;
      @(negedge clk);
      A2 = a; B2 = b; op_sub2 = sub; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done2 === 1'b1) begin
            lat = k;
            break;
         end
      end
      check({name, ".res"}, 64'(Result2), 64'(e_res));
      check({name, ".lat"}, 64'(lat), 64'(e_lat));
      check({name, ".flags"}, 64'({ovf2, unf2}), 64'd0);
   endtask

   initial begin
      logic seen;
      reset_n = 1'b0;
      start = 1'b0; op_sub = 1'b0; A = '0; B = '0;
      start2 = 1'b0; op_sub2 = 1'b0; A2 = '0; B2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(Done), 64'd0);
      check("rst.result", 64'(Result), 64'd0);
      check("rst.flags", 64'({ovf_flag, unf_flag}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1.0 + 1.0: carry normalise
      op_check("add_carry", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 0, 32'h4000_0000, 4, 1'b0, 1'b0);

      // Done lasts exactly one cycle
      @(posedge clk); #1;
      check("done_width", 64'(Done), 64'd0);

      // 3.0 - 1.0: one align shift, already normalised
      op_check("sub_3m1", 32'h4040_0000, 32'h3F80_0000, 1'b1, 0, 32'h4000_0000, 4, 1'b0, 1'b0);
      // 1.0 - 0.75: one align shift, two left shifts
      op_check("sub_lsh2", 32'h3F80_0000, 32'h3F40_0000, 1'b1, 0, 32'h3E80_0000, 6, 1'b0, 1'b0);
      // 1.5 - 1.5 = +0
      op_check("sub_zero", 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 0, 32'h0000_0000, 3, 1'b0, 1'b0);
      // -2.0 + 1.0 = -1.0
      op_check("neg_add", 32'hC000_0000, 32'h3F80_0000, 1'b0, 0, 32'hBF80_0000, 5, 1'b0, 1'b0);
      // exponent gap 30 > 24: bypass
      op_check("bypass", 32'h3F80_0000, 32'h3080_0000, 1'b0, 0, 32'h3F80_0000, 3, 1'b0, 1'b0);
      // max + max overflows
      op_check("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 32'h7F80_0000, 4, 1'b1, 1'b0);
      // inf - inf = canonical NaN, overflow flag cleared by new start
      op_check("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 0, 32'h7FC0_0000, 3, 1'b0, 1'b0);
      // -inf + 1.0 = -inf
      op_check("ninf_fin", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 0, 32'hFF80_0000, 3, 1'b0, 1'b0);
      // signalling-style NaN input becomes canonical NaN
      op_check("nan_in", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 0, 32'h7FC0_0000, 3, 1'b0, 1'b0);
      // 1.5*2^-126 - 2^-126 underflows to +0
      op_check("unf", 32'h00C0_0000, 32'h0080_0000, 1'b1, 0, 32'h0000_0000, 4, 1'b0, 1'b1);
      // start while busy is ignored
      op_check("busy_poke", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1, 32'h4000_0000, 4, 1'b0, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (Done === 1'b1) seen = 1'b1;
      end
      check("poke_no_2nd_done", 64'(seen), 64'd0);

      // reset during ALIGN (1.0 + 0.25 needs two align shifts)
      @(negedge clk);
      A = 32'h3F80_0000; B = 32'h3E80_0000; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("align.busy", 64'(busy), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.done", 64'(Done), 64'd0);
      check("abort.result", 64'(Result), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (Done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("abort.quiet", 64'(seen), 64'd0);

      // operation after the abort still works
      op_check("post_abort", 32'h3F80_0000, 32'h3E80_0000, 1'b0, 0, 32'h3FA0_0000, 5, 1'b0, 1'b0);

      // half precision instance
      run_half("h_add", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4);
      run_half("h_sub", 16'h3C00, 16'h3800, 1'b1, 16'h3800, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
